music_seq_player: RTL

- Parametrised note sequencer that plays a song from an internal note RAM.
- The RAM is loaded at run time by the UART command decoder, one note per write.
- Each played entry is output as a tone code to the downstream tone/frequency generator for its coded duration.
- Adds over the previous player: run-time song load, tempo-independent ms prescaler, pause/resume, stop, loop mode, articulation gap, end-of-song detection and status outputs.

---
 rtl/music_seq_player_pkg.sv | 23 ++
 rtl/music_seq_player_if.sv | 34 +++
 rtl/music_seq_player_ms_tick_gen.sv | 30 +++
 rtl/music_seq_player.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/music_seq_player_pkg.sv
// Shared types and constants for the note sequencer: state encoding,
// duration table and the end-of-song test.
package music_pkg;

  localparam int REST_TONE = 0;

  // Duration in ms per 3-bit code; a zero entry marks end of song.
  localparam int DUR_MS [0:7] = '{0, 200, 500, 1000, 2000, 4000, 0, 0};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_END
  } state_t;

  function automatic logic is_end(input logic [2:0] dur_code);
    return DUR_MS[dur_code] == 0;
  endfunction

endpackage

// File: rtl/music_seq_player_if.sv
// Control/status bundle between the command decoder, the sequencer and the
// tone generator; dbg_state mirrors the sequencer FSM for checkers.
interface music_seq_player_if #(
  parameter int AW     = 7,
  parameter int TONE_W = 5
) ();
  import music_pkg::*;

  // All strobes (wr_en, play, stop) are single-cycle pulses sampled on the
  // rising clock edge with no back-pressure; pause and loop_en are levels.
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [TONE_W+2:0] wr_data;
  logic              play;
  logic              stop;
  logic              pause;
  logic              loop_en;
  logic [TONE_W-1:0] music_tone;
  logic              busy;
  logic [AW-1:0]     note_idx;
  logic              song_done;
  state_t            dbg_state;

  modport master (
    output wr_en, wr_addr, wr_data, play, stop, pause, loop_en,
    input  music_tone, busy, note_idx, song_done, dbg_state
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, play, stop, pause, loop_en,
    output music_tone, busy, note_idx, song_done, dbg_state
  );

endinterface

// File: rtl/music_seq_player_ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every CLK_FREQ_HZ/1000 enabled cycles.
module ms_tick_gen #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int TC = CLK_FREQ_HZ / 1000 - 1;
  localparam int CW = (TC > 0) ? $clog2(TC + 1) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_at_tc;

  assign w_at_tc = (r_cnt == CW'(TC));
  assign tick    = en && w_at_tc;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_at_tc ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/music_seq_player.sv
// Note sequencer: plays {tone, dur_code} entries from a run-time loaded RAM,
// with ms-based durations, articulation gap, pause, stop and loop support.
module music_seq_player
  import music_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DEPTH       = 128,
  parameter int TONE_W      = 5,
  parameter int GAP_MS      = 20
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  music_seq_player_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  state_t            r_state, w_next;
  logic [TONE_W+2:0] r_ram [DEPTH];
  logic [TONE_W+2:0] r_rd_data;
  logic [AW-1:0]     r_idx;
  logic              r_last;
  logic [TONE_W-1:0] r_tone, r_music_tone;
  logic [15:0]       r_cnt;
  logic              r_song_done;

  logic [TONE_W-1:0] w_rd_tone, w_tone_d;
  logic [2:0]        w_rd_dur;
  logic              w_tick, w_tick_en, w_tick_clr;
  logic              w_idx_clr, w_idx_inc, w_last_d, w_tone_ld;
  logic              w_cnt_ld, w_cnt_dec, w_done_d;
  logic [15:0]       w_cnt_val;

  assign w_rd_tone = r_rd_data[TONE_W+2:3];
  assign w_rd_dur  = r_rd_data[2:0];

  // Read data is captured in FETCH and consumed in LOAD.
  always_ff @(posedge sys_clk) begin
    if (bus.wr_en) r_ram[bus.wr_addr] <= bus.wr_data;
    if (r_state == ST_FETCH) r_rd_data <= r_ram[r_idx];
  end

  assign w_tick_en  = ((r_state == ST_PLAY) || (r_state == ST_GAP)) && !bus.pause;
  assign w_tick_clr = ((w_next == ST_PLAY) && (r_state != ST_PLAY)) ||
                      ((w_next == ST_GAP)  && (r_state != ST_GAP));

  ms_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .en       (w_tick_en),
    .clr      (w_tick_clr),
    .tick     (w_tick)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.stop) begin
      w_next = ST_IDLE;
    end else if (bus.play) begin
      w_next = ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH: w_next = ST_LOAD;
        ST_LOAD:  w_next = (is_end(w_rd_dur) || r_last) ? ST_END : ST_PLAY;
        ST_PLAY:  if (w_tick && r_cnt == 16'd1) w_next = (GAP_MS > 0) ? ST_GAP : ST_FETCH;
        ST_GAP:   if (w_tick && r_cnt == 16'd1) w_next = ST_FETCH;
        ST_END:   w_next = bus.loop_en ? ST_FETCH : ST_IDLE;
        default:  w_next = r_state;
      endcase
    end
  end

  // The counter reloads on the last tick, so a note lasts exactly its table
  // value in ms of unpaused PLAY cycles.
  always_comb begin
    w_tone_d  = r_music_tone;
    w_idx_clr = 1'b0;
    w_idx_inc = 1'b0;
    w_last_d  = r_last;
    w_tone_ld = 1'b0;
    w_cnt_ld  = 1'b0;
    w_cnt_val = 16'd0;
    w_cnt_dec = 1'b0;
    w_done_d  = 1'b0;
    if (bus.stop || bus.play) begin
      w_tone_d  = TONE_W'(REST_TONE);
      w_idx_clr = 1'b1;
      w_last_d  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: w_tone_d = TONE_W'(REST_TONE);
        ST_LOAD: begin
          if (!(is_end(w_rd_dur) || r_last)) begin
            w_tone_ld = 1'b1;
            w_tone_d  = w_rd_tone;
            w_cnt_ld  = 1'b1;
            w_cnt_val = 16'(DUR_MS[w_rd_dur]);
          end
        end
        ST_PLAY: begin
          w_tone_d = bus.pause ? TONE_W'(REST_TONE) : r_tone;
          if (w_tick) begin
            if (r_cnt == 16'd1) begin
              if (GAP_MS > 0) begin
                w_tone_d  = TONE_W'(REST_TONE);
                w_cnt_ld  = 1'b1;
                w_cnt_val = 16'(GAP_MS);
              end else begin
                w_idx_inc = 1'b1;
                w_last_d  = (r_idx == AW'(DEPTH - 1));
              end
            end else begin
              w_cnt_dec = 1'b1;
            end
          end
        end
        ST_GAP: begin
          w_tone_d = TONE_W'(REST_TONE);
          if (w_tick) begin
            if (r_cnt == 16'd1) begin
              w_idx_inc = 1'b1;
              w_last_d  = (r_idx == AW'(DEPTH - 1));
            end else begin
              w_cnt_dec = 1'b1;
            end
          end
        end
        ST_END: begin
          w_tone_d = TONE_W'(REST_TONE);
          if (bus.loop_en) begin
            w_idx_clr = 1'b1;
            w_last_d  = 1'b0;
          end else begin
            w_done_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_idx        <= '0;
      r_last       <= 1'b0;
      r_tone       <= '0;
      r_cnt        <= '0;
      r_music_tone <= '0;
      r_song_done  <= 1'b0;
    end else begin
      r_music_tone <= w_tone_d;
      r_song_done  <= w_done_d;
      r_last       <= w_last_d;
      if (w_tone_ld) r_tone <= w_rd_tone;
      if (w_idx_clr)      r_idx <= '0;
      else if (w_idx_inc) r_idx <= r_idx + AW'(1);
      if (w_cnt_ld)       r_cnt <= w_cnt_val;
      else if (w_cnt_dec) r_cnt <= r_cnt - 16'd1;
    end
  end

  assign bus.music_tone = r_music_tone;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.note_idx   = r_idx;
  assign bus.song_done  = r_song_done;
  assign bus.dbg_state  = r_state;

endmodule
